// File: rtl/buzzer_pkg.sv
// -----------------------------------------------------------------------------
// buzzer_pkg
// Shared definitions for the buzzer pattern sequencer:
//   - state_t        : FSM state encoding (IDLE / ON / OFF)
//   - DEF_CNT_W      : default width of the on/off duration counters (ms ticks)
//   - DEF_BEEP_W     : default width of the beep-count field
//   - pattern_t      : one complete beep pattern (on time, off time, beep count)
//   - LEGACY_PATTERN : the pattern of the old fixed 3-beep buzzer counter
//   - pattern_active : true when a pattern actually produces sound
// -----------------------------------------------------------------------------
package buzzer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_BEEP_W = 4;

  typedef struct packed {
    logic [DEF_CNT_W-1:0]  on_ms;
    logic [DEF_CNT_W-1:0]  off_ms;
    logic [DEF_BEEP_W-1:0] beeps;
  } pattern_t;

  // Drop-in replacement for the legacy fixed sequence: 3 x (50 ms on, 50 ms off).
  localparam pattern_t LEGACY_PATTERN = '{
    on_ms:  16'd50,
    off_ms: 16'd50,
    beeps:  4'd3
  };

  // A pattern with no beeps or a zero on-time completes at once, silently.
  function automatic logic pattern_active(input logic beeps_nz, input logic on_nz);
    return beeps_nz & on_nz;
  endfunction

endpackage

// File: rtl/tick_cnt.sv
// -----------------------------------------------------------------------------
// tick_cnt
// Tick-gated up counter with synchronous clear and a terminal-count flag.
// The counter advances only on i_tick and returns to zero by itself when it
// reaches i_last, so it never wraps past the programmed bound. One instance is
// shared by the ON and OFF phases of the sequencer; the owner switches i_last.
//
// Ports:
//   i_clk   in   1      clock
//   i_rstn  in   1      asynchronous active-low reset
//   i_clr   in   1      synchronous clear (wins over i_tick)
//   i_tick  in   1      count enable (one 1 kHz tick)
//   i_last  in   CNT_W  terminal count value (phase length - 1)
//   o_tc    out  1      terminal count reached on this tick (combinational)
// -----------------------------------------------------------------------------
module tick_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clr,
  input  logic             i_tick,
  input  logic [CNT_W-1:0] i_last,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == i_last);
  // A clear on the same cycle means the phase is being restarted, so the
  // coinciding tick must not finish it.
  assign o_tc      = i_tick & w_at_last & ~i_clr;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      if (w_at_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/buzzer_seq.sv
// -----------------------------------------------------------------------------
// buzzer_seq
// Parametrised buzzer pattern sequencer. On i_go it latches the pattern
// configuration and emits i_beeps beeps of i_on_ms ticks separated by
// i_off_ms ticks of silence (1 kHz ticks from the shared prescaler). Supports
// retrigger (i_go while busy restarts), abort (i_abort wins over everything)
// and busy/done status.
//
// Optional build macro:
//   BUZZER_TONE_EN  - when defined, o_buzzer toggles on every tick while ON
//                     (500 Hz square wave for passive buzzers), starting at 1
//                     on entry to ON. When undefined, o_buzzer is a steady
//                     level during ON. Status and timing are identical.
//
// Ports:
//   i_clk     in   1       system clock
//   i_rstn    in   1       asynchronous active-low reset
//   i_pls_1k  in   1       single-cycle 1 kHz tick
//   i_go      in   1       trigger: latch config, start or restart pattern
//   i_abort   in   1       stop: silence output and return to IDLE
//   i_on_ms   in   CNT_W   beep on-time in ticks
//   i_off_ms  in   CNT_W   gap off-time in ticks
//   i_beeps   in   BEEP_W  number of beeps
//   o_buzzer  out  1       buzzer drive (registered)
//   o_busy    out  1       high while a pattern is active (registered)
//   o_done    out  1       one-cycle pulse on normal completion (registered)
// -----------------------------------------------------------------------------
module buzzer_seq
  import buzzer_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int BEEP_W = DEF_BEEP_W
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_pls_1k,
  input  logic              i_go,
  input  logic              i_abort,
  input  logic [CNT_W-1:0]  i_on_ms,
  input  logic [CNT_W-1:0]  i_off_ms,
  input  logic [BEEP_W-1:0] i_beeps,
  output logic              o_buzzer,
  output logic              o_busy,
  output logic              o_done
);

  // State and latched configuration
  state_t            r_state;
  logic [CNT_W-1:0]  r_on_lat;
  logic [CNT_W-1:0]  r_off_lat;
  logic [BEEP_W-1:0] r_beeps_lat;
  logic [BEEP_W-1:0] r_beep_idx;
  logic              r_buzzer;
  logic              r_busy;
  logic              r_done;

  // Next-state / control
  state_t            w_state_next;
  logic [BEEP_W-1:0] w_beep_idx_next;
  logic              w_latch;
  logic              w_cnt_clr;
  logic              w_cnt_tick;
  logic [CNT_W-1:0]  w_cnt_last;
  logic              w_tc;
  logic              w_buzzer_next;
  logic              w_busy_next;
  logic              w_done_next;
  logic              w_cfg_active;

  assign w_cfg_active = pattern_active(i_beeps != '0, i_on_ms != '0);

  // Ticks are only counted while a pattern runs; in IDLE the counter rests at 0.
  assign w_cnt_tick = i_pls_1k & (r_state != ST_IDLE);

  // Shared counter: terminal value follows the current phase. Phase changes
  // always happen on a terminal tick, where the counter self-clears, so the
  // next phase always starts from zero.
  assign w_cnt_last = (r_state == ST_OFF) ? (r_off_lat - 1'b1) : (r_on_lat - 1'b1);

  tick_cnt #(
    .CNT_W (CNT_W)
  ) u_tick_cnt (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_clr  (w_cnt_clr),
    .i_tick (w_cnt_tick),
    .i_last (w_cnt_last),
    .o_tc   (w_tc)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= ST_IDLE;
      r_on_lat    <= '0;
      r_off_lat   <= '0;
      r_beeps_lat <= '0;
      r_beep_idx  <= '0;
      r_buzzer    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_beep_idx <= w_beep_idx_next;
      r_buzzer   <= w_buzzer_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      if (w_latch) begin
        r_on_lat    <= i_on_ms;
        r_off_lat   <= i_off_ms;
        r_beeps_lat <= i_beeps;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_beep_idx_next = r_beep_idx;
    w_latch         = 1'b0;
    w_cnt_clr       = 1'b0;
    w_done_next     = 1'b0;

    if (i_abort) begin
      // Abort beats a simultaneous go and never reports completion.
      w_state_next    = ST_IDLE;
      w_beep_idx_next = '0;
      w_cnt_clr       = 1'b1;
    end else if (i_go) begin
      // Start or retrigger: the running pattern is dropped without o_done.
      w_latch         = 1'b1;
      w_cnt_clr       = 1'b1;
      w_beep_idx_next = '0;
      if (w_cfg_active) begin
        w_state_next = ST_ON;
      end else begin
        w_state_next = ST_IDLE;
        w_done_next  = 1'b1;
      end
    end else begin
      unique case (r_state)
        ST_ON: begin
          if (w_tc) begin
            if (r_beep_idx == (r_beeps_lat - 1'b1)) begin
              // Last beep: no trailing gap.
              w_state_next    = ST_IDLE;
              w_beep_idx_next = '0;
              w_done_next     = 1'b1;
            end else begin
              w_beep_idx_next = r_beep_idx + 1'b1;
              // Zero off-time merges consecutive beeps into one long tone.
              w_state_next    = (r_off_lat == '0) ? ST_ON : ST_OFF;
            end
          end
        end
        ST_OFF: begin
          if (w_tc) begin
            w_state_next = ST_ON;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign w_busy_next = (w_state_next != ST_IDLE);

`ifdef BUZZER_TONE_EN
  // Passive buzzer: square wave at half the tick rate while ON. A fresh entry
  // into ON (including a retrigger) restarts the wave high.
  always_comb begin
    w_buzzer_next = 1'b0;
    if (w_state_next == ST_ON) begin
      if ((r_state != ST_ON) || w_latch) begin
        w_buzzer_next = 1'b1;
      end else if (i_pls_1k) begin
        w_buzzer_next = ~r_buzzer;
      end else begin
        w_buzzer_next = r_buzzer;
      end
    end
  end
`else
  // Active buzzer: steady level for the whole ON phase.
  always_comb begin
    w_buzzer_next = (w_state_next == ST_ON);
  end
`endif

  assign o_buzzer = r_buzzer;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule

// File: tb/tb_buzzer_seq.sv
// -----------------------------------------------------------------------------
// tb_buzzer_seq
// Self-checking bench for buzzer_seq. A table of pattern records (config plus
// expected on-ticks, busy-ticks, beep count) is applied in a loop; expected
// results are queued when the trigger is driven and popped when o_done
// appears. Hand-written sequences cover abort, abort+go, retrigger, the
// asynchronous reset and (when BUZZER_TONE_EN is defined) tone mode.
// -----------------------------------------------------------------------------
module tb_buzzer_seq;
  import buzzer_pkg::*;

  localparam int CNT_W  = 16;
  localparam int BEEP_W = 4;

  logic              i_clk    = 1'b0;
  logic              i_rstn   = 1'b1;
  logic              i_pls_1k = 1'b0;
  logic              i_go     = 1'b0;
  logic              i_abort  = 1'b0;
  logic [CNT_W-1:0]  i_on_ms  = '0;
  logic [CNT_W-1:0]  i_off_ms = '0;
  logic [BEEP_W-1:0] i_beeps  = '0;
  logic              o_buzzer;
  logic              o_busy;
  logic              o_done;

  buzzer_seq #(
    .CNT_W  (CNT_W),
    .BEEP_W (BEEP_W)
  ) dut (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_pls_1k (i_pls_1k),
    .i_go     (i_go),
    .i_abort  (i_abort),
    .i_on_ms  (i_on_ms),
    .i_off_ms (i_off_ms),
    .i_beeps  (i_beeps),
    .o_buzzer (o_buzzer),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int on_ms;
    int off_ms;
    int beeps;
    int period;   // clock cycles per 1 kHz tick
    bit go_tick;  // tick coincides with the go cycle
    bit active;   // pattern produces sound
    int high;     // ticks with o_buzzer high
    int busy;     // ticks with o_busy high
    int pulses;   // rising edges on o_buzzer
  } vec_t;

  typedef struct {
    bit active;
    int high;
    int busy;
    int pulses;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[8];

  int n_vec = 0;
  int n_err = 0;
  int m_high, m_busy, m_pulses, m_done;
  logic prev_buz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_meas();
    m_high   = 0;
    m_busy   = 0;
    m_pulses = 0;
    m_done   = 0;
  endtask

  // One clock cycle. Outputs are sampled 1 time unit after the edge.
  task automatic step(input bit tick);
    i_pls_1k = tick;
    if (tick && o_busy === 1'b1)   m_busy++;
    if (tick && o_buzzer === 1'b1) m_high++;
    prev_buz = o_buzzer;
    @(posedge i_clk);
    #1;
    i_pls_1k = 1'b0;
    i_go     = 1'b0;
    i_abort  = 1'b0;
    if (o_buzzer === 1'b1 && prev_buz !== 1'b1) m_pulses++;
    if (o_done === 1'b1) m_done++;
  endtask

  task automatic run_until_done(input int period, input int budget, input string name);
    int cyc;
    cyc = 0;
    while (m_done == 0 && cyc < budget) begin
      step((cyc % period) == (period - 1));
      cyc++;
    end
    if (m_done == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no o_done within %0d cycles", name, budget);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    exp_t head;
    clear_meas();
    i_on_ms  = CNT_W'(v.on_ms);
    i_off_ms = CNT_W'(v.off_ms);
    i_beeps  = BEEP_W'(v.beeps);
    i_go     = 1'b1;
    e.active = v.active;
    e.high   = v.high;
    e.busy   = v.busy;
    e.pulses = v.pulses;
    sb_q.push_back(e);
    step(v.go_tick);
    head = sb_q[0];
    check($sformatf("v%0d_lat_busy", idx), o_busy, head.active);
    check($sformatf("v%0d_lat_buz", idx), o_buzzer, head.active);
    check($sformatf("v%0d_lat_done", idx), o_done, !head.active);
    run_until_done(v.period, head.busy * v.period + 50, $sformatf("v%0d", idx));
    head = sb_q.pop_front();
    check($sformatf("v%0d_end_buz", idx), o_buzzer, 0);
    check($sformatf("v%0d_end_busy", idx), o_busy, 0);
    check($sformatf("v%0d_busy_ticks", idx), m_busy, head.busy);
`ifndef BUZZER_TONE_EN
    check($sformatf("v%0d_high_ticks", idx), m_high, head.high);
    check($sformatf("v%0d_beeps", idx), m_pulses, head.pulses);
`endif
    repeat (3) step(1'b0);
    check($sformatf("v%0d_done_once", idx), m_done, 1);
    $display("vec %0d on=%0d off=%0d beeps=%0d: busy_ticks=%0d high_ticks=%0d beeps_seen=%0d",
             idx, v.on_ms, v.off_ms, v.beeps, m_busy, m_high, m_pulses);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //               on                         off                        beeps                     per gt act high busy pulses
    vecs[0] = '{int'(LEGACY_PATTERN.on_ms), int'(LEGACY_PATTERN.off_ms), int'(LEGACY_PATTERN.beeps), 2, 0, 1, 150, 250, 3};
    vecs[1] = '{7,     7,     0,  1, 0, 0, 0,  0,   0};
    vecs[2] = '{0,     5,     2,  1, 0, 0, 0,  0,   0};
    vecs[3] = '{10,    0,     4,  3, 0, 1, 40, 40,  1};
    vecs[4] = '{3,     2,     1,  1, 1, 1, 3,  3,   1};
    vecs[5] = '{1,     1,     5,  1, 1, 1, 5,  9,   5};
    vecs[6] = '{5,     3,     15, 2, 0, 1, 75, 117, 15};
    vecs[7] = '{4,     65535, 1,  1, 1, 1, 4,  4,   1};

    // Reset
    #3 i_rstn = 1'b0;
    #4;
    check("rst_buz", o_buzzer, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    #20 i_rstn = 1'b1;
    @(posedge i_clk);
    #1;
    $display("reset released");

    // Table-driven patterns
    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i]);
    end

    // Abort during the 2nd beep
    clear_meas();
    i_on_ms = 16'd50; i_off_ms = 16'd50; i_beeps = 4'd3; i_go = 1'b1;
    step(1'b0);
    repeat (110) step(1'b1);
    check("abort_pre_busy", o_busy, 1);
`ifndef BUZZER_TONE_EN
    check("abort_pre_buz", o_buzzer, 1);
`endif
    i_abort = 1'b1;
    step(1'b1);
    check("abort_buz", o_buzzer, 0);
    check("abort_busy", o_busy, 0);
    m_pulses = 0;
    repeat (150) step(1'b1);
    check("abort_no_done", m_done, 0);
    check("abort_silent", m_pulses, 0);
    $display("abort during beep 2: done_seen=%0d", m_done);

    // Abort and go together, from IDLE and from a running pattern
    clear_meas();
    i_on_ms = 16'd5; i_off_ms = 16'd5; i_beeps = 4'd2;
    i_go = 1'b1; i_abort = 1'b1;
    step(1'b0);
    check("abgo_idle_busy", o_busy, 0);
    check("abgo_idle_buz", o_buzzer, 0);
    check("abgo_idle_done", o_done, 0);
    i_go = 1'b1;
    step(1'b0);
    repeat (3) step(1'b1);
    i_go = 1'b1; i_abort = 1'b1;
    step(1'b0);
    check("abgo_run_busy", o_busy, 0);
    check("abgo_run_buz", o_buzzer, 0);
    repeat (30) step(1'b1);
    check("abgo_no_done", m_done, 0);
    $display("abort+go: busy=%0d done_seen=%0d", o_busy, m_done);

    // Retrigger at tick 75 of a (50,50,3) run with (20,10,2)
    clear_meas();
    i_on_ms = 16'd50; i_off_ms = 16'd50; i_beeps = 4'd3; i_go = 1'b1;
    step(1'b0);
    repeat (75) step(1'b1);
    check("retrig_pre_gap", o_buzzer, 0);
    i_on_ms = 16'd20; i_off_ms = 16'd10; i_beeps = 4'd2; i_go = 1'b1;
    step(1'b1);
    check("retrig_start_buz", o_buzzer, 1);
    check("retrig_start_busy", o_busy, 1);
    check("retrig_no_old_done", m_done, 0);
    m_high = 0; m_busy = 0; m_pulses = 0;
    run_until_done(1, 200, "retrig");
    check("retrig_busy_ticks", m_busy, 50);
`ifndef BUZZER_TONE_EN
    check("retrig_high_ticks", m_high, 40);
    check("retrig_beeps", m_pulses, 1);
`endif
    repeat (5) step(1'b1);
    check("retrig_done_once", m_done, 1);
    $display("retrigger: busy_ticks=%0d high_ticks=%0d done_seen=%0d", m_busy, m_high, m_done);

    // Asynchronous reset in the middle of ON
    clear_meas();
    i_on_ms = 16'd10; i_off_ms = 16'd0; i_beeps = 4'd1; i_go = 1'b1;
    step(1'b0);
    repeat (3) step(1'b1);
    check("arst_pre_busy", o_busy, 1);
    #2 i_rstn = 1'b0;
    #1;
    check("arst_buz", o_buzzer, 0);
    check("arst_busy", o_busy, 0);
    check("arst_done", o_done, 0);
    #2 i_rstn = 1'b1;
    @(posedge i_clk);
    #1;
    repeat (20) step(1'b1);
    check("arst_stays_idle", o_busy, 0);
    check("arst_no_done", m_done, 0);
    $display("async reset mid-ON: busy=%0d", o_busy);

`ifdef BUZZER_TONE_EN
    // Tone mode: (8, 0, 1) gives 4 high and 4 low tick-phases
    clear_meas();
    i_on_ms = 16'd8; i_off_ms = 16'd0; i_beeps = 4'd1; i_go = 1'b1;
    step(1'b0);
    check("tone_start_buz", o_buzzer, 1);
    run_until_done(2, 100, "tone");
    check("tone_high_phases", m_high, 4);
    check("tone_low_phases", m_busy - m_high, 4);
    check("tone_end_buz", o_buzzer, 0);
    $display("tone mode: high_phases=%0d low_phases=%0d", m_high, m_busy - m_high);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
